// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, stall request and
// a saturating count of hazard-stall cycles.
module id_ex_pipe #(
   parameter int DATA_W = 8,
   parameter int REG_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [REG_W-1:0]  id_rs,
   input  logic              id_uses_rs,
   input  logic [REG_W-1:0]  id_writereg,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_osrc,
   input  logic [DATA_W-1:0] id_opa,
   input  logic [DATA_W-1:0] id_opb,
   input  logic              hold_in,
   input  logic              flush,
   output logic              ex_valid,
   output logic [REG_W-1:0]  ex_rd,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_writereg,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_osrc,
   output logic [DATA_W-1:0] ex_opa,
   output logic [DATA_W-1:0] ex_opb,
   output logic              stall_out,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              r_valid;
   logic [REG_W-1:0]  r_rd;
   logic [REG_W-1:0]  r_rs;
   logic [REG_W-1:0]  r_writereg;
   logic              r_regwrite;
   logic              r_memread;
   logic              r_osrc;
   logic [DATA_W-1:0] r_opa;
   logic [DATA_W-1:0] r_opb;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_rd_match;
   logic              w_rs_match;
   logic              w_hazard;

   // Load-use hazard: the load in EX writes a register the ID instruction reads.
   always_comb begin
      w_rd_match = (r_writereg == id_rd);
      w_rs_match = id_uses_rs & (r_writereg == id_rs);
      w_hazard   = r_valid & r_memread & r_regwrite & id_valid & (w_rd_match | w_rs_match);
      stall_out  = ~rst & ~flush & (w_hazard | hold_in);
   end

   // EX register update: reset > flush > hold > hazard bubble > load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_rd       <= {REG_W{1'b0}};
         r_rs       <= {REG_W{1'b0}};
         r_writereg <= {REG_W{1'b0}};
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_osrc     <= 1'b0;
         r_opa      <= {DATA_W{1'b0}};
         r_opb      <= {DATA_W{1'b0}};
         r_cnt      <= {CNT_W{1'b0}};
      end else if (flush || (!hold_in && w_hazard)) begin
         r_valid    <= 1'b0;
         r_rd       <= {REG_W{1'b0}};
         r_rs       <= {REG_W{1'b0}};
         r_writereg <= {REG_W{1'b0}};
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_osrc     <= 1'b0;
         r_opa      <= {DATA_W{1'b0}};
         r_opb      <= {DATA_W{1'b0}};
         // Only hazard bubbles are counted; flush bubbles are not stalls.
         if (!flush && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_cnt <= r_cnt;
         end
      end else if (hold_in) begin
         r_valid    <= r_valid;
         r_rd       <= r_rd;
         r_rs       <= r_rs;
         r_writereg <= r_writereg;
         r_regwrite <= r_regwrite;
         r_memread  <= r_memread;
         r_osrc     <= r_osrc;
         r_opa      <= r_opa;
         r_opb      <= r_opb;
         r_cnt      <= r_cnt;
      end else begin
         r_valid    <= id_valid;
         r_rd       <= id_rd;
         r_rs       <= id_rs;
         r_writereg <= id_writereg;
         r_regwrite <= id_regwrite;
         r_memread  <= id_memread;
         r_osrc     <= id_osrc;
         r_opa      <= id_opa;
         r_opb      <= id_opb;
         r_cnt      <= r_cnt;
      end
   end

   assign ex_valid    = r_valid;
   assign ex_rd       = r_rd;
   assign ex_rs       = r_rs;
   assign ex_writereg = r_writereg;
   assign ex_regwrite = r_regwrite;
   assign ex_memread  = r_memread;
   assign ex_osrc     = r_osrc;
   assign ex_opa      = r_opa;
   assign ex_opb      = r_opb;
   assign stall_cnt   = r_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: a reference model pushes expected EX
// state into a queue each cycle; a monitor pops and compares after the edge.
module tb_id_ex_pipe;

   localparam int DATA_W = 8;
   localparam int REG_W  = 3;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst, id_valid, id_uses_rs, id_regwrite, id_memread, id_osrc;
   logic [REG_W-1:0]  id_rd, id_rs, id_writereg;
   logic [DATA_W-1:0] id_opa, id_opb;
   logic              hold_in, flush;
   logic              ex_valid, ex_regwrite, ex_memread, ex_osrc, stall_out;
   logic [REG_W-1:0]  ex_rd, ex_rs, ex_writereg;
   logic [DATA_W-1:0] ex_opa, ex_opb;
   logic [CNT_W-1:0]  stall_cnt;

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  wr;
      logic              rw;
      logic              mr;
      logic              osrc;
      logic [DATA_W-1:0] opa;
      logic [DATA_W-1:0] opb;
      logic [CNT_W-1:0]  cnt;
   } ex_t;

   ex_t m_state;
   ex_t exp_q[$];
   int  errors = 0;
   int  checks = 0;

   id_ex_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_rs(id_rs),
      .id_uses_rs(id_uses_rs), .id_writereg(id_writereg), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_osrc(id_osrc), .id_opa(id_opa), .id_opb(id_opb),
      .hold_in(hold_in), .flush(flush), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_rs(ex_rs), .ex_writereg(ex_writereg), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_osrc(ex_osrc), .ex_opa(ex_opa), .ex_opb(ex_opb),
      .stall_out(stall_out), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic model_hazard(ex_t c);
      return c.valid & c.mr & c.rw & id_valid &
             ((c.wr == id_rd) | (id_uses_rs & (c.wr == id_rs)));
   endfunction

   function automatic ex_t model_next(ex_t c);
      ex_t n;
      n = '0;
      if (rst) n = '0;
      else if (flush) n.cnt = c.cnt;
      else if (hold_in) n = c;
      else if (model_hazard(c)) n.cnt = (c.cnt == 2'd3) ? 2'd3 : c.cnt + 2'd1;
      else begin
         n = '{id_valid, id_rd, id_rs, id_writereg, id_regwrite, id_memread,
               id_osrc, id_opa, id_opb, c.cnt};
      end
      return n;
   endfunction

   // Scoreboard monitor: compare DUT state with the oldest expected entry.
   always @(posedge clk) begin
      ex_t e, g;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = '{ex_valid, ex_rd, ex_rs, ex_writereg, ex_regwrite, ex_memread,
               ex_osrc, ex_opa, ex_opb, stall_cnt};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL ex_state got=%h exp=%h", g, e);
         end
      end
   end

   // One clock: check stall_out, push the expected EX state, advance.
   task automatic cycle();
      logic exp_stall;
      #1;
      exp_stall = ~rst & ~flush & (model_hazard(m_state) | hold_in);
      checks++;
      if (stall_out !== exp_stall) begin
         errors++;
         $display("FAIL stall_out got=%b exp=%b", stall_out, exp_stall);
      end
      m_state = model_next(m_state);
      exp_q.push_back(m_state);
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic [2:0] rd, input logic [2:0] rs,
                        input logic urs, input logic [2:0] wr, input logic rw,
                        input logic mr, input logic os, input logic [7:0] a,
                        input logic [7:0] b);
      id_valid = v; id_rd = rd; id_rs = rs; id_uses_rs = urs; id_writereg = wr;
      id_regwrite = rw; id_memread = mr; id_osrc = os; id_opa = a; id_opb = b;
   endtask

   task automatic test_reset();
      m_state = '0;
      rst = 1'b1; hold_in = 1'b0; flush = 1'b0;
      drive(1'b1, 3'd7, 3'd6, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h3C);
      @(posedge clk); #2;
      cycle();
      cycle();
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== 2'd0 || ex_opa !== 8'h00) begin
         errors++;
         $display("FAIL reset_state got=%b/%0d/%h exp=0/0/00", ex_valid, stall_cnt, ex_opa);
      end
      rst = 1'b0;
      drive(1'b1, 3'd1, 3'd2, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22);
      cycle();
      checks++;
      if (ex_opb !== 8'h22 || ex_osrc !== 1'b1) begin
         errors++;
         $display("FAIL reset_release got=%h/%b exp=22/1", ex_opb, ex_osrc);
      end
   endtask

   task automatic test_pass_through();
      drive(1'b1, 3'd3, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h5A);
      cycle();
      checks++;
      if (ex_rd !== 3'd3 || ex_writereg !== 3'd5 || ex_regwrite !== 1'b1 ||
          ex_opa !== 8'hA5 || ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL pass_through got=%0d/%0d/%b/%h/%b exp=3/5/1/a5/1",
                  ex_rd, ex_writereg, ex_regwrite, ex_opa, ex_valid);
      end
      drive(1'b0, 3'd2, 3'd4, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 8'h77, 8'h88);
      cycle();
   endtask

   task automatic test_load_use();
      drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 8'h10, 8'h20);
      cycle();
      drive(1'b1, 3'd4, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'hC3, 8'h3C);
      #1;
      checks++;
      if (stall_out !== 1'b1) begin
         errors++;
         $display("FAIL load_use_stall got=%b exp=1", stall_out);
      end
      cycle();
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== 2'd1) begin
         errors++;
         $display("FAIL load_use_bubble got=%b/%0d exp=0/1", ex_valid, stall_cnt);
      end
      cycle();
      checks++;
      if (ex_valid !== 1'b1 || ex_opa !== 8'hC3) begin
         errors++;
         $display("FAIL load_use_resume got=%b/%h exp=1/c3", ex_valid, ex_opa);
      end
   endtask

   task automatic test_unused_rs();
      drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h01, 8'h02);
      cycle();
      drive(1'b1, 3'd6, 3'd2, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h44, 8'h55);
      cycle();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 3'd6) begin
         errors++;
         $display("FAIL unused_rs got=%b/%0d exp=1/6", ex_valid, ex_rd);
      end
      drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h01, 8'h02);
      cycle();
      drive(1'b1, 3'd6, 3'd2, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'h44, 8'h55);
      cycle();
      cycle();
   endtask

   task automatic test_flush();
      logic [CNT_W-1:0] cnt_before;
      drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 8'h09, 8'h0A);
      cycle();
      cnt_before = m_state.cnt;
      drive(1'b1, 3'd4, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'h66, 8'h67);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== cnt_before) begin
         errors++;
         $display("FAIL flush_bubble got=%b/%0d exp=0/%0d", ex_valid, stall_cnt, cnt_before);
      end
   endtask

   task automatic test_hold();
      ex_t frozen;
      drive(1'b1, 3'd5, 3'd6, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 8'hBE, 8'hEF);
      cycle();
      frozen = m_state;
      hold_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'(i), 3'(i), 1'b0, 3'(i), 1'b0, 1'b0, 1'b0, 8'(i), 8'(i));
         cycle();
      end
      checks++;
      if (ex_opa !== frozen.opa || ex_writereg !== frozen.wr) begin
         errors++;
         $display("FAIL hold_frozen got=%h/%0d exp=%h/%0d", ex_opa, ex_writereg,
                  frozen.opa, frozen.wr);
      end
      hold_in = 1'b0;
      drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 8'h31, 8'h32);
      cycle();
      hold_in = 1'b1;
      drive(1'b1, 3'd3, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h41, 8'h42);
      cycle();
      cycle();
      hold_in = 1'b0;
      cycle();
      cycle();
   endtask

   task automatic test_saturation();
      drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h12, 8'h34);
      cycle();
      drive(1'b1, 3'd1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h56, 8'h78);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid_stall got=%b/%0d exp=0/0", ex_valid, stall_cnt);
      end
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'(i), 8'h00);
         cycle();
         drive(1'b1, 3'd1, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'(i));
         cycle();
         checks++;
         if (stall_cnt !== 2'((i > 3) ? 3 : i)) begin
            errors++;
            $display("FAIL saturate_%0d got=%0d exp=%0d", i, stall_cnt, (i > 3) ? 3 : i);
         end
         cycle();
      end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load_use();
      test_unused_rs();
      test_flush();
      test_hold();
      test_saturation();
      @(posedge clk); #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register for the 8-register core.
- Captures decoded fields and operands from the ID stage and presents them to the EX stage.
- Supplies the EX-side register address and operand-source select to the forwarding unit.
- Detects load-use hazards, stalls ID/IF, and inserts bubbles on hazard or branch flush.

Parameters:
- DATA_W, 8: operand data width.
- REG_W, 3: register address width (8 registers).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rd  input  REG_W  first source register.
- id_rs  input  REG_W  second source register.
- id_uses_rs  input  1  instruction reads id_rs.
- id_writereg  input  REG_W  destination register.
- id_regwrite  input  1  instruction writes the register file.
- id_memread  input  1  instruction is a load.
- id_osrc  input  1  operand source select (0 = register, 1 = immediate).
- id_opa  input  DATA_W  operand A.
- id_opb  input  DATA_W  operand B.
- hold_in  input  1  downstream busy; freeze EX contents.
- flush  input  1  branch taken; squash the ID instruction.
- ex_valid  output  1  EX holds a real instruction.
- ex_rd  output  REG_W  registered id_rd; feeds forwarding rd.
- ex_rs  output  REG_W  registered id_rs.
- ex_writereg  output  REG_W  registered destination register.
- ex_regwrite  output  1  registered write enable.
- ex_memread  output  1  registered load flag.
- ex_osrc  output  1  registered operand source; feeds forwarding osrc.
- ex_opa  output  DATA_W  registered operand A.
- ex_opb  output  DATA_W  registered operand B.
- stall_out  output  1  combinational; hold PC and IF/ID.
- stall_cnt  output  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset: all ex_* outputs = 0 and stall_cnt = 0 on the first rising edge with rst = 1. stall_out = 0 while rst = 1. Reset mid-stall discards the pending instruction.
- hazard (combinational) = ex_valid & ex_memread & ex_regwrite & id_valid & ((ex_writereg == id_rd) | (id_uses_rs & (ex_writereg == id_rs))). Register 0 gets no special treatment.
- Per-edge update priority:
  1. rst: clear everything.
  2. flush: bubble.
  3. hold_in: keep all ex_* unchanged.
  4. hazard: bubble.
  5. otherwise: load all id_* into ex_*, with ex_valid = id_valid.
- Bubble: ex_valid, ex_regwrite, ex_memread and ex_osrc = 0. ex_rd, ex_rs, ex_writereg, ex_opa and ex_opb = 0.
- Latency: one cycle from ID to EX.
- stall_out = ~rst & ~flush & (hazard | hold_in). Flush suppresses stall because the ID instruction is squashed.
- Load-use stall lasts exactly one cycle. After the bubble, ex_memread = 0, so hazard drops and the held ID instruction loads on the next edge.
- hold_in together with hazard: EX is frozen (hold wins). The hazard persists until hold_in drops, then one bubble follows.
- stall_cnt increments by 1 on each edge where hazard is taken (priority 4 path). It saturates at 2^CNT_W − 1 and does not wrap. Hold cycles are not counted.
- id_valid = 0 with no hold/flush: EX loads with ex_valid = 0. Other fields are loaded as presented; downstream qualifies them with ex_valid.

Test Plan:
- Reset: drive rst = 1 for 2 cycles with nonzero ID inputs -> all ex_* = 0, stall_cnt = 0, stall_out = 0. Release rst -> next edge loads ID fields.
- Pass-through: id_rd = 3, id_writereg = 5, id_regwrite = 1, id_osrc = 0, id_opa = 8'hA5, no hold/flush -> one cycle later ex_rd = 3, ex_writereg = 5, ex_regwrite = 1, ex_opa = 8'hA5, ex_valid = 1.
- Load-use: EX holds a load with ex_writereg = 4; ID has id_rd = 4 -> stall_out = 1 for exactly one cycle, EX shows a bubble (ex_valid = 0), stall_cnt = 1. The next edge loads the ID instruction.
- No hazard on an unused rs: EX load writes reg 2; ID has id_rs = 2, id_uses_rs = 0, id_rd = 6 -> stall_out = 0, normal load.
- Flush vs hazard: create the hazard condition and assert flush in the same cycle -> stall_out = 0, EX bubble, stall_cnt unchanged.
- Hold, then saturation: hold_in = 1 for 3 cycles -> ex_* frozen, stall_cnt unchanged. With CNT_W = 2, trigger 5 hazards -> stall_cnt stops at 3.
